fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Owns the fetch PC register and tracks predictor state from IF through ID to EX.
- Consumes the branch predictor's hit, predicted target, wrong-prediction code and ALU target. Produces the next fetch PC, flush, the EX-stage hit bit and PC, and the predictor update enable.
- Sits between the branch predictor and the I-cache/IF stage.
- Holds a redirect while the I-cache is busy with a miss, so the redirect is not lost.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- PC_W, 32, PC/target width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- fetch_stall_i  in  1  I-cache miss: freeze PC, insert bubble into ID.
- pipe_stall_i  in  1  hazard: freeze PC, ID and EX registers.
- hit_i  in  1  predictor hit for pc_o.
- predicted_pc_i  in  PC_W  predictor target for pc_o.
- wrong_predicted_i  in  2  01 = predicted taken but not taken; 10 = not-taken/wrong target; 00 = correct.
- alu_pc_i  in  PC_W  resolved branch/jump target from EX.
- pc_o  out  PC_W  current fetch PC.
- pc_id_o  out  PC_W  ID-stage PC.
- pc_ex_o  out  PC_W  EX-stage PC.
- valid_id_o  out  1  ID stage holds a live instruction.
- valid_ex_o  out  1  EX stage holds a live instruction.
- hit_ex_o  out  1  hit bit carried to EX.
- flush_o  out  1  kill IF/ID contents this cycle.
- bp_update_en_o  out  1  predictor table write enable.
- redirect_pend_o  out  1  a redirect is held pending.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: pc_o = RESET_PC; pc_id_o and pc_ex_o = 0; valid_id_o, valid_ex_o, hit_ex_o, flush_o and bp_update_en_o = 0; state = RUN.
- resolve = valid_ex_o & ~pipe_stall_i.
- bp_update_en_o = resolve (combinational).
- mispredict = resolve & (wrong_predicted_i != 00).
- Redirect target:
  - wrong_predicted_i = 10: alu_pc_i.
  - wrong_predicted_i = 01: pc_ex_o + 4.
- flush_o = mispredict (combinational, same cycle).
- Next sequential PC: if hit_i then predicted_pc_i, else pc_o + 4. Modulo 2^PC_W (wraps).
- FSM state RUN:
  - mispredict & ~fetch_stall_i: pc_o <= target; valid_id <= 0; valid_ex <= 0.
  - mispredict & fetch_stall_i: pend_pc <= target; valid_id <= 0; valid_ex <= 0; go to PEND.
  - pipe_stall_i (no mispredict): PC, ID and EX all hold.
  - fetch_stall_i only: PC holds; ID <= bubble (valid 0); EX <= ID.
  - Otherwise: pc <= next sequential PC; ID <= {pc_o, hit_i, 1}; EX <= ID.
- FSM state PEND (redirect_pend_o = 1):
  - ID and EX receive bubbles.
  - mispredict cannot fire, since valid_ex_o = 0.
  - When fetch_stall_i = 0: pc_o <= pend_pc; go to RUN.
  - pipe_stall_i is ignored in PEND.
- Simultaneous events:
  - mispredict beats pipe_stall_i: it cannot occur, because resolve requires ~pipe_stall_i.
  - Redirect beats hit_i.
- hit_ex_o holds the hit bit latched with the EX instruction. It is forced 0 when valid_ex_o = 0.
- rst_i mid-PEND: pending target discarded; returns to RESET_PC.
- wrong_predicted_i = 11: treated as 10.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, add two 32-bit outputs, counted only when bp_update_en_o = 1:
  - br_resolved_o: increments every cycle bp_update_en_o = 1.
  - br_mispred_o: increments on mispredict.
- Both counters clear on rst_i and saturate at 32'hFFFF_FFFF.
- When not defined, both ports still exist and are tied to 0, and no counter flops are built.

Test Plan:
- Reset, then 3 clean cycles with hit_i = 0 -> pc_o goes 0 -> 4 -> 8 -> C; valid_ex_o = 1 at cycle 3; flush_o = 0.
- hit_i = 1, predicted_pc_i = 0x100 at pc_o = 0x8 -> next pc_o = 0x100; two cycles later pc_ex_o = 0x8, hit_ex_o = 1.
- EX instruction at pc_ex_o = 0x20 with wrong_predicted_i = 01 -> flush_o = 1 the same cycle; next pc_o = 0x24; valid_id_o = valid_ex_o = 0.
- wrong_predicted_i = 10, alu_pc_i = 0x400 while fetch_stall_i = 1 for 3 cycles -> redirect_pend_o = 1 and pc_o held during the stall; pc_o = 0x400 on the cycle after fetch_stall_i drops.
- pipe_stall_i = 1 with wrong_predicted_i = 10 -> bp_update_en_o = 0, no flush, all registers held; the redirect occurs the cycle pipe_stall_i drops.
- BP_PERF_CNT_EN defined: 5 resolves including 2 mispredicts -> br_resolved_o = 5, br_mispred_o = 2; after rst_i both read 0.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Owns the fetch PC and carries predictor state (PC, hit bit, valid) from IF
// through ID to EX. When EX resolves a branch that the predictor got wrong,
// it redirects fetch and kills the younger IF/ID work. If the I-cache is busy
// with a miss at that moment, the redirect target is parked in PEND until the
// miss clears, so the redirect cannot be lost.
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   fetch_stall_i      I-cache miss: freeze PC, bubble into ID
//   pipe_stall_i       hazard: freeze PC, ID and EX
//   hit_i              predictor hit for pc_o
//   predicted_pc_i     predictor target for pc_o
//   wrong_predicted_i  00 correct, 01 predicted taken but not taken,
//                      10/11 not taken or wrong target
//   alu_pc_i           resolved branch/jump target from EX
//   pc_o               current fetch PC
//   pc_id_o, pc_ex_o   ID / EX stage PCs
//   valid_id_o         ID holds a live instruction
//   valid_ex_o         EX holds a live instruction
//   hit_ex_o           hit bit travelling with the EX instruction
//   flush_o            kill IF/ID contents this cycle
//   bp_update_en_o     predictor table write enable
//   redirect_pend_o    a redirect is held pending
//   br_resolved_o      resolved-branch counter (0 unless BP_PERF_CNT_EN)
//   br_mispred_o       mispredict counter       (0 unless BP_PERF_CNT_EN)
//
// Optional build macro: BP_PERF_CNT_EN enables the two saturating counters.
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_stall_i,
    input  logic            pipe_stall_i,
    input  logic            hit_i,
    input  logic [PC_W-1:0] predicted_pc_i,
    input  logic [1:0]      wrong_predicted_i,
    input  logic [PC_W-1:0] alu_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_id_o,
    output logic [PC_W-1:0] pc_ex_o,
    output logic            valid_id_o,
    output logic            valid_ex_o,
    output logic            hit_ex_o,
    output logic            flush_o,
    output logic            bp_update_en_o,
    output logic            redirect_pend_o,
    output logic [31:0]     br_resolved_o,
    output logic [31:0]     br_mispred_o
);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pend_pc_reg, pend_pc_next;
    logic [PC_W-1:0] pc_id_reg, pc_id_next;
    logic [PC_W-1:0] pc_ex_reg, pc_ex_next;
    logic            hit_id_reg, hit_id_next;
    logic            hit_ex_reg, hit_ex_next;
    logic            valid_id_reg, valid_id_next;
    logic            valid_ex_reg, valid_ex_next;

    logic            resolve;
    logic            mispredict;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] seq_pc;

    // A stalled EX instruction has not really resolved yet, so neither the
    // predictor update nor a redirect may happen while pipe_stall_i is high.
    assign resolve    = valid_ex_reg & ~pipe_stall_i;
    assign mispredict = resolve & (wrong_predicted_i != 2'b00);
    // 01 means "should have fallen through"; 10 and 11 both take the ALU target.
    assign target     = (wrong_predicted_i == 2'b01) ? (pc_ex_reg + PC_W'(4)) : alu_pc_i;
    assign seq_pc     = hit_i ? predicted_pc_i : (pc_reg + PC_W'(4));

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pend_pc_next  = pend_pc_reg;
        pc_id_next    = pc_id_reg;
        hit_id_next   = hit_id_reg;
        valid_id_next = valid_id_reg;
        pc_ex_next    = pc_ex_reg;
        hit_ex_next   = hit_ex_reg;
        valid_ex_next = valid_ex_reg;

        case (state_reg)
            RUN: begin
                if (mispredict) begin
                    valid_id_next = 1'b0;
                    valid_ex_next = 1'b0;
                    if (fetch_stall_i) begin
                        pend_pc_next = target;
                        state_next   = PEND;
                    end else begin
                        pc_next = target;
                    end
                end else if (pipe_stall_i) begin
                    // everything holds
                end else if (fetch_stall_i) begin
                    valid_id_next = 1'b0;
                    pc_ex_next    = pc_id_reg;
                    hit_ex_next   = hit_id_reg;
                    valid_ex_next = valid_id_reg;
                end else begin
                    pc_next       = seq_pc;
                    pc_id_next    = pc_reg;
                    hit_id_next   = hit_i;
                    valid_id_next = 1'b1;
                    pc_ex_next    = pc_id_reg;
                    hit_ex_next   = hit_id_reg;
                    valid_ex_next = valid_id_reg;
                end
            end
            PEND: begin
                // Pipeline is empty while waiting; pipe_stall_i has nothing to hold.
                valid_id_next = 1'b0;
                valid_ex_next = 1'b0;
                if (!fetch_stall_i) begin
                    pc_next    = pend_pc_reg;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_PC;
            pend_pc_reg  <= '0;
            pc_id_reg    <= '0;
            hit_id_reg   <= 1'b0;
            valid_id_reg <= 1'b0;
            pc_ex_reg    <= '0;
            hit_ex_reg   <= 1'b0;
            valid_ex_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pend_pc_reg  <= pend_pc_next;
            pc_id_reg    <= pc_id_next;
            hit_id_reg   <= hit_id_next;
            valid_id_reg <= valid_id_next;
            pc_ex_reg    <= pc_ex_next;
            hit_ex_reg   <= hit_ex_next;
            valid_ex_reg <= valid_ex_next;
        end
    end

    assign pc_o            = pc_reg;
    assign pc_id_o         = pc_id_reg;
    assign pc_ex_o         = pc_ex_reg;
    assign valid_id_o      = valid_id_reg;
    assign valid_ex_o      = valid_ex_reg;
    assign hit_ex_o        = hit_ex_reg & valid_ex_reg;
    assign flush_o         = mispredict;
    assign bp_update_en_o  = resolve;
    assign redirect_pend_o = (state_reg == PEND);

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_resolved_reg;
    logic [31:0] br_mispred_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_resolved_reg <= '0;
            br_mispred_reg  <= '0;
        end else begin
            if (resolve && (br_resolved_reg != 32'hFFFF_FFFF))
                br_resolved_reg <= br_resolved_reg + 32'd1;
            if (mispredict && (br_mispred_reg != 32'hFFFF_FFFF))
                br_mispred_reg <= br_mispred_reg + 32'd1;
        end
    end

    assign br_resolved_o = br_resolved_reg;
    assign br_mispred_o  = br_mispred_reg;
`else
    assign br_resolved_o = '0;
    assign br_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed scenarios, expected fetch PCs
// queued when stimulus is applied and compared after each clock edge.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stall;
    logic        pipe_stall;
    logic        hit;
    logic [31:0] predicted_pc;
    logic [1:0]  wrong;
    logic [31:0] alu_pc;
    logic [31:0] pc_o, pc_id_o, pc_ex_o;
    logic        valid_id_o, valid_ex_o, hit_ex_o, flush_o, bp_update_en_o, redirect_pend_o;
    logic [31:0] br_resolved_o, br_mispred_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pc_q[$];

    fetch_redirect_ctrl #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .fetch_stall_i     (fetch_stall),
        .pipe_stall_i      (pipe_stall),
        .hit_i             (hit),
        .predicted_pc_i    (predicted_pc),
        .wrong_predicted_i (wrong),
        .alu_pc_i          (alu_pc),
        .pc_o              (pc_o),
        .pc_id_o           (pc_id_o),
        .pc_ex_o           (pc_ex_o),
        .valid_id_o        (valid_id_o),
        .valid_ex_o        (valid_ex_o),
        .hit_ex_o          (hit_ex_o),
        .flush_o           (flush_o),
        .bp_update_en_o    (bp_update_en_o),
        .redirect_pend_o   (redirect_pend_o),
        .br_resolved_o     (br_resolved_o),
        .br_mispred_o      (br_mispred_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst          = 1'b0;
        fetch_stall  = 1'b0;
        pipe_stall   = 1'b0;
        hit          = 1'b0;
        predicted_pc = 32'h0;
        wrong        = 2'b00;
        alu_pc       = 32'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        hit = 1'b1;
        predicted_pc = 32'h1234;
        rst = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", pc_o, 32'h0); end
        checks++;
        if ({pc_id_o, pc_ex_o} !== 64'h0) begin failures++; $display("FAIL reset_stage_pcs actual=%h/%h expected=0/0", pc_id_o, pc_ex_o); end
        checks++;
        if ({valid_id_o, valid_ex_o, hit_ex_o, flush_o, bp_update_en_o, redirect_pend_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b expected=000000",
                     {valid_id_o, valid_ex_o, hit_ex_o, flush_o, bp_update_en_o, redirect_pend_o});
        end
        checks++;
        if ({br_resolved_o, br_mispred_o} !== 64'h0) begin failures++; $display("FAIL reset_counters actual=%0d/%0d expected=0/0", br_resolved_o, br_mispred_o); end
        drive_idle();
        $display("reset done pc_o=%h", pc_o);
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        pc_q.push_back(32'h4);
        pc_q.push_back(32'h8);
        pc_q.push_back(32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = pc_q.pop_front();
            checks++;
            if (pc_o !== e) begin failures++; $display("FAIL seq_pc actual=%h expected=%h", pc_o, e); end
            checks++;
            if (flush_o !== 1'b0) begin failures++; $display("FAIL seq_flush actual=%b expected=0", flush_o); end
            $display("seq cycle %0d pc_o=%h", i + 1, pc_o);
        end
        checks++;
        if (valid_ex_o !== 1'b1) begin failures++; $display("FAIL seq_valid_ex actual=%b expected=1", valid_ex_o); end
        checks++;
        if ({pc_id_o, pc_ex_o} !== {32'h8, 32'h4}) begin failures++; $display("FAIL seq_stage_pcs actual=%h/%h expected=8/4", pc_id_o, pc_ex_o); end
    endtask

    task automatic test_hit();
        logic        h_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] p_t [7] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0};
        logic [31:0] e_t [7] = '{32'h4, 32'h8, 32'h100, 32'h104, 32'h108, 32'hFFFF_FFFC, 32'h0};
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            hit = h_t[i];
            predicted_pc = p_t[i];
            pc_q.push_back(e_t[i]);
            tick();
            e = pc_q.pop_front();
            checks++;
            if (pc_o !== e) begin failures++; $display("FAIL hit_pc actual=%h expected=%h", pc_o, e); end
            if (i == 3) begin
                checks++;
                if ({pc_ex_o, hit_ex_o} !== {32'h8, 1'b1}) begin failures++; $display("FAIL hit_ex_carry actual=%h/%b expected=8/1", pc_ex_o, hit_ex_o); end
            end
            if (i == 4) begin
                checks++;
                if ({pc_ex_o, hit_ex_o} !== {32'h100, 1'b0}) begin failures++; $display("FAIL hit_ex_clear actual=%h/%b expected=100/0", pc_ex_o, hit_ex_o); end
            end
            $display("hit cycle %0d hit=%b pc_o=%h", i, h_t[i], pc_o);
        end
        drive_idle();
    endtask

    task automatic test_mispredict_01();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pc_q.push_back(32'(4 * (i + 1)));
            tick();
            e = pc_q.pop_front();
            checks++;
            if (pc_o !== e) begin failures++; $display("FAIL mp01_run_pc actual=%h expected=%h", pc_o, e); end
        end
        checks++;
        if ({pc_ex_o, valid_ex_o} !== {32'h20, 1'b1}) begin failures++; $display("FAIL mp01_ex actual=%h/%b expected=20/1", pc_ex_o, valid_ex_o); end
        wrong = 2'b01;
        alu_pc = 32'hDEAD_0000;
        hit = 1'b1;
        predicted_pc = 32'h900;
        #1;
        checks++;
        if ({flush_o, bp_update_en_o} !== 2'b11) begin failures++; $display("FAIL mp01_flush actual=%b%b expected=11", flush_o, bp_update_en_o); end
        pc_q.push_back(32'h24);
        tick();
        e = pc_q.pop_front();
        checks++;
        if (pc_o !== e) begin failures++; $display("FAIL mp01_redirect_pc actual=%h expected=%h", pc_o, e); end
        drive_idle();
        #1;
        checks++;
        if ({valid_id_o, valid_ex_o, flush_o} !== 3'b000) begin failures++; $display("FAIL mp01_killed actual=%b%b%b expected=000", valid_id_o, valid_ex_o, flush_o); end
        $display("mispredict01 redirect pc_o=%h", pc_o);
    endtask

    task automatic test_redirect_pend();
        logic [31:0] e;
        do_reset();
        pc_q.push_back(32'h4); tick(); e = pc_q.pop_front();
        pc_q.push_back(32'h8); tick(); e = pc_q.pop_front();
        fetch_stall = 1'b1;
        wrong = 2'b10;
        alu_pc = 32'h400;
        #1;
        checks++;
        if (flush_o !== 1'b1) begin failures++; $display("FAIL pend_flush actual=%b expected=1", flush_o); end
        for (int i = 0; i < 3; i++) begin
            pc_q.push_back(32'h8);
            tick();
            wrong = 2'b00;
            e = pc_q.pop_front();
            checks++;
            if (pc_o !== e) begin failures++; $display("FAIL pend_hold_pc actual=%h expected=%h", pc_o, e); end
            checks++;
            if ({redirect_pend_o, valid_ex_o} !== 2'b10) begin failures++; $display("FAIL pend_state actual=%b%b expected=10", redirect_pend_o, valid_ex_o); end
            $display("pend cycle %0d pc_o=%h pend=%b", i, pc_o, redirect_pend_o);
        end
        fetch_stall = 1'b0;
        pipe_stall = 1'b1;
        pc_q.push_back(32'h400);
        tick();
        pipe_stall = 1'b0;
        e = pc_q.pop_front();
        checks++;
        if ({pc_o, redirect_pend_o} !== {e, 1'b0}) begin failures++; $display("FAIL pend_release actual=%h/%b expected=%h/0", pc_o, redirect_pend_o, e); end
        pc_q.push_back(32'h404);
        tick();
        e = pc_q.pop_front();
        checks++;
        if ({pc_o, pc_id_o, valid_id_o} !== {e, 32'h400, 1'b1}) begin failures++; $display("FAIL pend_resume actual=%h/%h/%b expected=%h/400/1", pc_o, pc_id_o, valid_id_o, e); end
        // Reset while a redirect is parked must discard it.
        tick();
        fetch_stall = 1'b1;
        wrong = 2'b10;
        alu_pc = 32'h700;
        tick();
        wrong = 2'b00;
        checks++;
        if (redirect_pend_o !== 1'b1) begin failures++; $display("FAIL pend_enter2 actual=%b expected=1", redirect_pend_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({pc_o, redirect_pend_o} !== {32'h0, 1'b0}) begin failures++; $display("FAIL pend_reset actual=%h/%b expected=0/0", pc_o, redirect_pend_o); end
        fetch_stall = 1'b0;
        pc_q.push_back(32'h4);
        tick();
        e = pc_q.pop_front();
        checks++;
        if (pc_o !== e) begin failures++; $display("FAIL pend_discard actual=%h expected=%h", pc_o, e); end
        $display("pend after reset pc_o=%h", pc_o);
        drive_idle();
    endtask

    task automatic test_stalls();
        logic [31:0] e;
        do_reset();
        tick();
        tick();
        pipe_stall = 1'b1;
        wrong = 2'b10;
        alu_pc = 32'h300;
        #1;
        checks++;
        if ({bp_update_en_o, flush_o} !== 2'b00) begin failures++; $display("FAIL pstall_no_resolve actual=%b%b expected=00", bp_update_en_o, flush_o); end
        for (int i = 0; i < 2; i++) begin
            pc_q.push_back(32'h8);
            tick();
            e = pc_q.pop_front();
            checks++;
            if ({pc_o, pc_id_o, pc_ex_o, valid_ex_o} !== {e, 32'h4, 32'h0, 1'b1}) begin
                failures++;
                $display("FAIL pstall_hold actual=%h/%h/%h/%b expected=%h/4/0/1", pc_o, pc_id_o, pc_ex_o, valid_ex_o, e);
            end
            $display("pipe_stall cycle %0d pc_o=%h", i, pc_o);
        end
        pipe_stall = 1'b0;
        #1;
        checks++;
        if ({bp_update_en_o, flush_o} !== 2'b11) begin failures++; $display("FAIL pstall_release actual=%b%b expected=11", bp_update_en_o, flush_o); end
        pc_q.push_back(32'h300);
        tick();
        wrong = 2'b00;
        e = pc_q.pop_front();
        checks++;
        if ({pc_o, valid_ex_o} !== {e, 1'b0}) begin failures++; $display("FAIL pstall_redirect actual=%h/%b expected=%h/0", pc_o, valid_ex_o, e); end
        tick();
        tick();
        fetch_stall = 1'b1;
        pc_q.push_back(32'h308);
        tick();
        fetch_stall = 1'b0;
        e = pc_q.pop_front();
        checks++;
        if ({pc_o, valid_id_o, pc_ex_o, valid_ex_o} !== {e, 1'b0, 32'h304, 1'b1}) begin
            failures++;
            $display("FAIL fstall_bubble actual=%h/%b/%h/%b expected=%h/0/304/1", pc_o, valid_id_o, pc_ex_o, valid_ex_o, e);
        end
        $display("fetch_stall pc_o=%h pc_ex_o=%h", pc_o, pc_ex_o);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        do_reset();
        tick();
        tick();
        wrong = 2'b11;
        alu_pc = 32'h500;
        pc_q.push_back(32'h500);
        tick();
        wrong = 2'b00;
        e = pc_q.pop_front();
        checks++;
        if (pc_o !== e) begin failures++; $display("FAIL wp11_target actual=%h expected=%h", pc_o, e); end
        tick();
        tick();
        checks++;
        if ({pc_ex_o, valid_ex_o} !== {32'h500, 1'b1}) begin failures++; $display("FAIL b2b_refill actual=%h/%b expected=500/1", pc_ex_o, valid_ex_o); end
        wrong = 2'b01;
        alu_pc = 32'hBAD0;
        pc_q.push_back(32'h504);
        tick();
        wrong = 2'b00;
        e = pc_q.pop_front();
        checks++;
        if (pc_o !== e) begin failures++; $display("FAIL b2b_second_redirect actual=%h expected=%h", pc_o, e); end
        $display("back_to_back pc_o=%h", pc_o);
        drive_idle();
    endtask

    task automatic test_perf();
        logic [1:0]  w_t [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        logic [31:0] exp_res;
        logic [31:0] exp_mis;
`ifdef BP_PERF_CNT_EN
        exp_res = 32'd5;
        exp_mis = 32'd2;
`else
        exp_res = 32'd0;
        exp_mis = 32'd0;
`endif
        do_reset();
        alu_pc = 32'h40;
        for (int i = 0; i < 9; i++) begin
            wrong = w_t[i];
            tick();
        end
        wrong = 2'b00;
        tick();
        checks++;
        if ({br_resolved_o, br_mispred_o} !== {exp_res, exp_mis}) begin
            failures++;
            $display("FAIL perf_counts actual=%0d/%0d expected=%0d/%0d", br_resolved_o, br_mispred_o, exp_res, exp_mis);
        end
        $display("perf resolved=%0d mispred=%0d", br_resolved_o, br_mispred_o);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({br_resolved_o, br_mispred_o} !== 64'h0) begin failures++; $display("FAIL perf_clear actual=%0d/%0d expected=0/0", br_resolved_o, br_mispred_o); end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_sequential();
        test_hit();
        test_mispredict_01();
        test_redirect_pend();
        test_stalls();
        test_back_to_back();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
